// File: rtl/encoder4_2_debounce.sv
// Debounced, registered 4-to-2 priority encoder for asynchronous key/switch lines.
// A one-cycle strobe marks every accepted change of the request vector.
module encoder4_2_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [1:0] code,
  output logic       code_valid,
  output logic       multi_err,
  output logic       code_stb
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  state_t           state;
  logic [3:0]       req_p0;
  logic [3:0]       req_s;
  logic [3:0]       snapshot;
  logic [CNT_W-1:0] cnt;

  function automatic logic [1:0] prio_idx(input logic [3:0] v);
    if (v[3])      prio_idx = 2'b11;
    else if (v[2]) prio_idx = 2'b10;
    else if (v[1]) prio_idx = 2'b01;
    else           prio_idx = 2'b00;
  endfunction

  function automatic logic more_than_one(input logic [3:0] v);
    more_than_one = ($countones(v) > 1);
  endfunction

  // Stage p0 -> s: two-flop synchroniser, free-running regardless of enable
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_p0 <= '0;
      req_s  <= '0;
    end else begin
      req_p0 <= req;
      req_s  <= req_p0;
    end
  end

  // Debounce FSM: snapshot tracks req_s; a vector is accepted once it stays put long enough
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      snapshot   <= '0;
      cnt        <= '0;
      code       <= 2'b00;
      code_valid <= 1'b0;
      multi_err  <= 1'b0;
      code_stb   <= 1'b0;
    end else begin
      code_stb <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        snapshot   <= '0;
        cnt        <= '0;
        code       <= 2'b00;
        code_valid <= 1'b0;
        multi_err  <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (req_s != snapshot) begin
              snapshot <= req_s;
              cnt      <= '0;
              state    <= SETTLE;
            end
          end
          SETTLE: begin
            if (req_s != snapshot) begin
              snapshot <= req_s;
              cnt      <= '0;
            end else if (cnt == CNT_LAST) begin
              cnt       <= '0;
              code_stb  <= 1'b1;
              multi_err <= more_than_one(snapshot);
              if (snapshot != 4'b0000) begin
                code       <= prio_idx(snapshot);
                code_valid <= 1'b1;
                state      <= HOLD;
              end else begin
                code       <= 2'b00;
                code_valid <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_encoder4_2_debounce.sv
// Bench for encoder4_2_debounce (DEBOUNCE_CYC=4): directed scenarios plus random traffic,
// checked every cycle against a history-window reference model.
module tb_encoder4_2_debounce;

  localparam int D = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       enable;
  logic [3:0] req;
  logic [1:0] code;
  logic       code_valid;
  logic       multi_err;
  logic       code_stb;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  encoder4_2_debounce #(.DEBOUNCE_CYC(D)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .req        (req),
    .code       (code),
    .code_valid (code_valid),
    .multi_err  (multi_err),
    .code_stb   (code_stb)
  );

  // Reference model: the value seen at each edge is the request from two edges earlier,
  // or zero when disabled. A vector is accepted at edge m when that value changed at edge
  // m-D and then held (enabled) through edge m.
  typedef struct packed {
    logic       en;
    logic [3:0] w;
  } obs_t;

  logic [3:0] rq[$];
  obs_t       wq[$];
  logic [1:0] m_code;
  logic       m_valid;
  logic       m_multi;
  logic       m_stb;

  function automatic logic [1:0] top_idx(input logic [3:0] v);
    top_idx = 2'b00;
    for (int i = 0; i < 4; i++)
      if (v[i]) top_idx = 2'(i);
  endfunction

  task automatic model_clear();
    rq = {4'd0, 4'd0};
    wq.delete();
    for (int i = 0; i < D + 2; i++) wq.push_back('0);
    m_code  = 2'b00;
    m_valid = 1'b0;
    m_multi = 1'b0;
    m_stb   = 1'b0;
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      model_clear();
    end else begin
      logic [3:0] rs;
      obs_t       cur;
      bit         acc;
      rs = rq.pop_front();
      rq.push_back(req);
      cur.en = enable;
      cur.w  = enable ? rs : 4'd0;
      wq.push_back(cur);
      void'(wq.pop_front());
      acc = enable && (wq[0].w != wq[1].w);
      for (int i = 1; i <= D + 1; i++)
        if (!wq[i].en || wq[i].w != wq[1].w) acc = 1'b0;
      m_stb = acc;
      if (!enable) begin
        m_code  = 2'b00;
        m_valid = 1'b0;
        m_multi = 1'b0;
      end else if (acc) begin
        m_code  = top_idx(cur.w);
        m_valid = (cur.w != 4'd0);
        m_multi = ($countones(cur.w) > 1);
      end
    end
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    cmp({tag, "_code"},  8'(code),       8'(m_code));
    cmp({tag, "_valid"}, 8'(code_valid), 8'(m_valid));
    cmp({tag, "_multi"}, 8'(multi_err),  8'(m_multi));
    cmp({tag, "_stb"},   8'(code_stb),   8'(m_stb));
  endtask

  task automatic cycle(input string tag);
    @(negedge sys_clk);
    if (code_stb === 1'b1) stb_cnt++;
    chk_model(tag);
  endtask

  // Returns the edge number (1-based) after which the strobe was first seen, or 0 if never.
  task automatic wait_stb(input string tag, input int max_edges, output int edges);
    edges = 0;
    for (int i = 1; i <= max_edges; i++) begin
      cycle(tag);
      if (code_stb === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] c, input logic v,
                         input logic m, input logic s);
    cmp({tag, "_code"},  8'(code),       8'(c));
    cmp({tag, "_valid"}, 8'(code_valid), 8'(v));
    cmp({tag, "_multi"}, 8'(multi_err),  8'(m));
    cmp({tag, "_stb"},   8'(code_stb),   8'(s));
  endtask

  initial begin
    int e;
    int s0;
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    req       = 4'd0;
    repeat (2) @(negedge sys_clk);
    chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    enable    = 1'b1;
    repeat (2) cycle("idle");

    // Single key: change before edge k, outputs after edge k+D+2
    req = 4'b0010;
    wait_stb("single", 20, e);
    cmp("single_lat", 8'(e), 8'(D + 3));
    chk_out("single_out", 2'b01, 1'b1, 1'b0, 1'b1);
    cycle("single_after");
    cmp("single_stb_drop", 8'(code_stb), 8'd0);

    // Async reset in the middle of settling
    req = 4'b0100;
    repeat (3) cycle("pre_rst");
    #2 sys_rst_n = 1'b0;
    #1 chk_out("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_stb("after_rst", 20, e);
    cmp("after_rst_lat", 8'(e), 8'(D + 3));
    chk_out("after_rst_out", 2'b10, 1'b1, 1'b0, 1'b1);

    // Priority with several keys down
    req = 4'b1011;
    wait_stb("multi", 20, e);
    cmp("multi_lat", 8'(e), 8'(D + 3));
    chk_out("multi_out", 2'b11, 1'b1, 1'b1, 1'b1);
    s0 = stb_cnt;
    repeat (8) cycle("multi_hold");
    cmp("multi_one_stb", 8'(stb_cnt - s0), 8'd0);

    // Bounce: each level lasts only 2 cycles, nothing may be accepted
    s0 = stb_cnt;
    for (int i = 0; i < 10; i++) begin
      req = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (2) cycle("bounce");
    end
    cmp("bounce_no_stb", 8'(stb_cnt - s0), 8'd0);
    chk_out("bounce_held", 2'b11, 1'b1, 1'b1, 1'b0);
    req = 4'b0001;
    wait_stb("bounce_end", 20, e);
    cmp("bounce_end_lat", 8'(e), 8'(D + 3));
    chk_out("bounce_end_out", 2'b00, 1'b1, 1'b0, 1'b1);

    // Release back to no key
    req = 4'b0000;
    wait_stb("release", 20, e);
    cmp("release_lat", 8'(e), 8'(D + 3));
    chk_out("release_out", 2'b00, 1'b0, 1'b0, 1'b1);

    // Enable drop while holding, then re-enable with the key still down
    req = 4'b1000;
    wait_stb("en_acc", 20, e);
    chk_out("en_acc_out", 2'b11, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle("en_hold");
    enable = 1'b0;
    cycle("en_off");
    chk_out("en_off_out", 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle("en_off_hold");
    enable = 1'b1;
    wait_stb("en_on", 20, e);
    cmp("en_on_seen", 8'((e > 0) && (e <= D + 2)), 8'd1);
    chk_out("en_on_out", 2'b11, 1'b1, 1'b0, 1'b1);

    // Random traffic, including short glitches and enable drops
    for (int n = 0; n < 60; n++) begin
      req    = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 9)) cycle("rand");
    end
    enable = 1'b1;
    repeat (10) cycle("rand_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
